// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Op codes, FSM state encoding and requester indices shared by
//                the ALU arbiter and its round-robin grant logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] c_op_add  = 4'b0010;
    localparam logic [3:0] c_op_orr  = 4'b0100;
    localparam logic [3:0] c_op_nor  = 4'b0101;
    localparam logic [3:0] c_op_and  = 4'b0110;
    localparam logic [3:0] c_op_cbz  = 4'b0111;
    localparam logic [3:0] c_op_eor  = 4'b1001;
    localparam logic [3:0] c_op_sub  = 4'b1010;
    localparam logic [3:0] c_op_nand = 4'b1100;
    localparam logic [3:0] c_op_mov  = 4'b1101;

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_setup   = 3'd1;
    localparam logic [2:0] c_st_exec    = 3'd2;
    localparam logic [2:0] c_st_capture = 3'd3;
    localparam logic [2:0] c_st_resp    = 3'd4;

    localparam logic c_req_exec   = 1'b0;
    localparam logic c_req_branch = 1'b1;

    function automatic logic op_supported(input logic [3:0] op);
        case (op)
            c_op_add, c_op_orr, c_op_nor, c_op_and, c_op_cbz,
            c_op_eor, c_op_sub, c_op_nand, c_op_mov: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin grant; the pointer breaks ties only.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import alu_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       pointer,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant[c_req_exec]   = 1'b1;
            2'b10:   grant[c_req_branch] = 1'b1;
            2'b11:   grant[pointer]      = 1'b1;
            default: grant = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Shares one ALU between the execute stage and the branch unit,
//                sequencing SETUP/EXEC/CAPTURE and holding the response.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [3:0]       req_op0,
    input  logic [3:0]       req_op1,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_zero,
    output logic             resp_err,
    output logic [WIDTH-1:0] alu_data1,
    output logic [WIDTH-1:0] alu_data2,
    output logic [3:0]       alu_ctrl,
    output logic             alu_enable,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    logic [2:0]       r_state;
    logic             r_ptr;
    logic             r_owner;
    logic [WIDTH-1:0] r_alu_data1;
    logic [WIDTH-1:0] r_alu_data2;
    logic [3:0]       r_alu_ctrl;
    logic [WIDTH-1:0] r_resp_data;
    logic             r_resp_zero;
    logic             r_resp_err;

    logic [1:0]       w_grant;
    logic [1:0]       w_accept;
    logic             w_accept_idx;
    logic [3:0]       w_op;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;

    rr_arb2 u_rr_arb2 (
        .valid   (req_valid),
        .pointer (r_ptr),
        .grant   (w_grant)
    );

    assign req_ready    = (r_state == c_st_idle) ? w_grant : 2'b00;
    assign w_accept     = req_valid & req_ready;
    assign w_accept_idx = w_accept[c_req_branch];
    assign w_op         = w_accept_idx ? req_op1 : req_op0;
    assign w_a          = w_accept_idx ? req_a1  : req_a0;
    assign w_b          = w_accept_idx ? req_b1  : req_b0;

    // Decoded from state so that an asynchronous reset clears them at once.
    assign alu_enable = (r_state == c_st_exec);
    always_comb begin
        resp_valid = 2'b00;
        if (r_state == c_st_resp) begin
            resp_valid[r_owner] = 1'b1;
        end
    end

    assign alu_data1 = r_alu_data1;
    assign alu_data2 = r_alu_data2;
    assign alu_ctrl  = r_alu_ctrl;
    assign resp_data = r_resp_data;
    assign resp_zero = r_resp_zero;
    assign resp_err  = r_resp_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_ptr       <= c_req_exec;
            r_owner     <= c_req_exec;
            r_alu_data1 <= '0;
            r_alu_data2 <= '0;
            r_alu_ctrl  <= '0;
            r_resp_data <= '0;
            r_resp_zero <= 1'b0;
            r_resp_err  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (|w_accept) begin
                        r_owner <= w_accept_idx;
                        r_ptr   <= ~w_accept_idx;
                        // ALU drive registers only move for ops that issue,
                        // so they hold their last values across error responses.
                        if (op_supported(w_op)) begin
                            r_alu_data1 <= w_a;
                            r_alu_data2 <= w_b;
                            r_alu_ctrl  <= w_op;
                            r_state     <= c_st_setup;
                        end else begin
                            r_resp_data <= '0;
                            r_resp_zero <= 1'b0;
                            r_resp_err  <= 1'b1;
                            r_state     <= c_st_resp;
                        end
                    end
                end
                c_st_setup: r_state <= c_st_exec;
                c_st_exec:  r_state <= c_st_capture;
                c_st_capture: begin
                    if (r_alu_ctrl == c_op_cbz) begin
                        r_resp_data <= '0;
                        r_resp_zero <= alu_zero;
                    end else begin
                        r_resp_data <= alu_result;
                        r_resp_zero <= 1'b0;
                    end
                    r_resp_err <= 1'b0;
                    r_state    <= c_st_resp;
                end
                c_st_resp: begin
                    if (resp_ready[r_owner]) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Directed self-checking bench for alu_arbiter with a simple
//                behavioural ALU attached to the shared ALU port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [3:0]       req_op0;
    logic [3:0]       req_op1;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b1;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_ready;
    logic [WIDTH-1:0] resp_data;
    logic             resp_zero;
    logic             resp_err;
    logic [WIDTH-1:0] alu_data1;
    logic [WIDTH-1:0] alu_data2;
    logic [3:0]       alu_ctrl;
    logic             alu_enable;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    int vec_count;
    int miscompares;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op0    (req_op0),
        .req_op1    (req_op1),
        .req_a0     (req_a0),
        .req_b0     (req_b0),
        .req_a1     (req_a1),
        .req_b1     (req_b1),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_zero  (resp_zero),
        .resp_err   (resp_err),
        .alu_data1  (alu_data1),
        .alu_data2  (alu_data2),
        .alu_ctrl   (alu_ctrl),
        .alu_enable (alu_enable),
        .alu_result (alu_result),
        .alu_zero   (alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: evaluates on the clock edge that closes the enable cycle.
    function automatic logic [WIDTH-1:0] alu_fn(input logic [3:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (op)
            4'b0010: return a + b;
            4'b0100: return a | b;
            4'b0101: return ~(a | b);
            4'b0110: return a & b;
            4'b0111: return b;
            4'b1001: return a ^ b;
            4'b1010: return a - b;
            4'b1100: return ~(a & b);
            4'b1101: return b;
            default: return '0;
        endcase
    endfunction

    initial begin
        alu_result = '0;
        alu_zero   = 1'b0;
    end
    always @(posedge clk) begin
        if (alu_enable) begin
            alu_result <= alu_fn(alu_ctrl, alu_data1, alu_data2);
            alu_zero   <= (alu_fn(alu_ctrl, alu_data1, alu_data2) == '0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "simulation timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_count++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called one cycle after acceptance; walks to the response, optionally
    // stalls resp_ready, then retires the response.
    task automatic finish_txn(input string tag, input logic [1:0] owner, input int lat,
                              input logic [31:0] d, input logic z, input logic e,
                              input int stall);
        int pulses;
        pulses = 0;
        for (int c = 1; c < lat; c++) begin
            if (alu_enable) pulses++;
            chk({tag, "_en"}, 32'(alu_enable), (c == 2) ? 32'd1 : 32'd0);
            chk({tag, "_pend_valid"}, 32'(resp_valid), 32'd0);
            tick();
        end
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'(owner));
        chk({tag, "_resp_data"}, resp_data, d);
        chk({tag, "_resp_zero"}, 32'(resp_zero), 32'(z));
        chk({tag, "_resp_err"}, 32'(resp_err), 32'(e));
        for (int s = 0; s < stall; s++) begin
            tick();
            chk({tag, "_stall_valid"}, 32'(resp_valid), 32'(owner));
            chk({tag, "_stall_data"}, resp_data, d);
            chk({tag, "_stall_ready"}, 32'(req_ready), 32'd0);
        end
        resp_ready = owner;
        tick();
        resp_ready = 2'b00;
        chk({tag, "_retired"}, 32'(resp_valid), 32'd0);
        chk({tag, "_pulses"}, 32'(pulses), (lat == 4) ? 32'd1 : 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_data"}, resp_data, 32'd0);
        chk({tag, "_resp_zero"}, 32'(resp_zero), 32'd0);
        chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        chk({tag, "_alu_data1"}, alu_data1, 32'd0);
        chk({tag, "_alu_data2"}, alu_data2, 32'd0);
        chk({tag, "_alu_ctrl"}, 32'(alu_ctrl), 32'd0);
        chk({tag, "_alu_enable"}, 32'(alu_enable), 32'd0);
    endtask

    initial begin
        vec_count   = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        req_valid   = 2'b00;
        resp_ready  = 2'b00;
        req_op0     = '0;
        req_op1     = '0;
        req_a0      = '0;
        req_b0      = '0;
        req_a1      = '0;
        req_b1      = '0;

        #3;
        chk_all_zero("reset");
        #5 rst_n = 1'b1;
        tick();

        // Single ADD from the execute stage
        req_op0 = 4'b0010; req_a0 = 32'd5; req_b0 = 32'd7; req_valid = 2'b01;
        #1 chk("add_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        chk("add_setup_ctrl", 32'(alu_ctrl), 32'h2);
        chk("add_setup_a", alu_data1, 32'd5);
        chk("add_setup_b", alu_data2, 32'd7);
        finish_txn("add", 2'b01, 4, 32'd12, 1'b0, 1'b0, 0);

        // CBZ from the branch unit, zero and non-zero operand
        req_op1 = 4'b0111; req_a1 = 32'd9; req_b1 = 32'd0; req_valid = 2'b10;
        #1 chk("cbz0_ready", 32'(req_ready), 32'd2);
        tick();
        req_valid = 2'b00;
        finish_txn("cbz0", 2'b10, 4, 32'd0, 1'b1, 1'b0, 0);
        req_b1 = 32'd3; req_valid = 2'b10;
        #1 chk("cbz3_ready", 32'(req_ready), 32'd2);
        tick();
        req_valid = 2'b00;
        finish_txn("cbz3", 2'b10, 4, 32'd0, 1'b0, 1'b0, 0);

        // Simultaneous requests with the pointer on the execute stage
        req_op0 = 4'b0010; req_a0 = 32'd1; req_b0 = 32'd2;
        req_op1 = 4'b1010; req_a1 = 32'd9; req_b1 = 32'd4;
        req_valid = 2'b11;
        #1 chk("tie1_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b10;
        finish_txn("tie_add", 2'b01, 4, 32'd3, 1'b0, 1'b0, 0);
        #1 chk("tie2_ready", 32'(req_ready), 32'd2);
        tick();
        req_valid = 2'b00;
        finish_txn("tie_sub", 2'b10, 4, 32'd5, 1'b0, 1'b0, 0);
        req_a0 = 32'hFFFF_FFFF; req_b0 = 32'd1;
        req_valid = 2'b11;
        #1 chk("tie3_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        finish_txn("wrap_add", 2'b01, 4, 32'd0, 1'b0, 1'b0, 0);

        // Unsupported op: error response, ALU drive holds previous values
        req_op0 = 4'b1111; req_a0 = 32'h1234; req_b0 = 32'h5678; req_valid = 2'b01;
        #1 chk("err_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        chk("err_hold_ctrl", 32'(alu_ctrl), 32'h2);
        chk("err_hold_a", alu_data1, 32'hFFFF_FFFF);
        finish_txn("err", 2'b01, 1, 32'd0, 1'b0, 1'b1, 0);

        // Stalled response with the branch unit waiting
        req_op0 = 4'b1001; req_a0 = 32'h0000_F0F0; req_b0 = 32'h0000_FF00; req_valid = 2'b01;
        #1 chk("stall_ready", 32'(req_ready), 32'd1);
        tick();
        req_op1 = 4'b0101; req_a1 = 32'd0; req_b1 = 32'd0; req_valid = 2'b10;
        finish_txn("stall_eor", 2'b01, 4, 32'h0000_0FF0, 1'b0, 1'b0, 5);
        #1 chk("after_stall_ready", 32'(req_ready), 32'd2);
        tick();
        req_valid = 2'b00;
        finish_txn("nor", 2'b10, 4, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);

        // Reset while the ALU is enabled
        req_op0 = 4'b0110; req_a0 = 32'hF0; req_b0 = 32'h3C; req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        chk("rst_exec_en", 32'(alu_enable), 32'd1);
        rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("midrst_no_resp", 32'(resp_valid), 32'd0);
        end
        req_op0 = 4'b0100; req_a0 = 32'hF0; req_b0 = 32'h0F; req_valid = 2'b01;
        #1 chk("post_rst_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        finish_txn("post_rst_orr", 2'b01, 4, 32'hFF, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
